// File: rtl/lift_ctrl.sv
// Single-car SCAN elevator controller with timed floor travel and door dwell.
// Optional emergency recall to floor 0 is enabled by defining LIFT_EMERG_EN.
module lift_ctrl #(
  parameter int NUM_FLOORS  = 8,
  parameter int FLOOR_W     = 3,
  parameter int MOVE_CYCLES = 4,
  parameter int DOOR_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_FLOORS-1:0] call_req,
  input  logic [NUM_FLOORS-1:0] car_req,
`ifdef LIFT_EMERG_EN
  input  logic                  emerg_i,
`endif
  output logic [FLOOR_W-1:0]    floor_o,
  output logic                  door_open_o,
  output logic                  moving_o,
  output logic                  dir_up_o,
  output logic                  busy_o,
  output logic [NUM_FLOORS-1:0] pending_o
);

  localparam int TMR_MAX = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] MOVE_LAST = TMR_W'(MOVE_CYCLES - 1);
  localparam logic [TMR_W-1:0] DOOR_LAST = TMR_W'(DOOR_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MOVE  = 2'd1,
`ifdef LIFT_EMERG_EN
    DOOR  = 2'd2,
    EMERG = 2'd3
`else
    DOOR  = 2'd2
`endif
  } state_t;

  state_t                  state, state_nx;
  logic [FLOOR_W-1:0]      floor_nx;
  logic                    dir_nx;
  logic [TMR_W-1:0]        timer, timer_nx;
  logic [NUM_FLOORS-1:0]   pending_nx, req, clr;
  logic                    door_nx;

  function automatic logic any_ahead(input logic [NUM_FLOORS-1:0] pend,
                                     input logic [FLOOR_W-1:0] fl,
                                     input logic up);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++)
      if (pend[i] && (up ? (i > int'(fl)) : (i < int'(fl))))
        hit = 1'b1;
    return hit;
  endfunction

  // Saturating single-floor step so the car can never leave the shaft.
  function automatic logic [FLOOR_W-1:0] step_floor(input logic [FLOOR_W-1:0] fl,
                                                    input logic up);
    if (up && (fl != FLOOR_W'(NUM_FLOORS - 1)))
      return fl + FLOOR_W'(1);
    else if (!up && (fl != '0))
      return fl - FLOOR_W'(1);
    else
      return fl;
  endfunction

  always_comb begin
    state_nx = state;
    floor_nx = floor_o;
    dir_nx   = dir_up_o;
    timer_nx = timer;
    req      = call_req | car_req;
    case (state)
      IDLE: begin
        timer_nx = '0;
        if (pending_o[floor_o])
          state_nx = DOOR;
        else if (any_ahead(pending_o, floor_o, 1'b1)) begin
          dir_nx   = 1'b1;
          state_nx = MOVE;
        end else if (any_ahead(pending_o, floor_o, 1'b0)) begin
          dir_nx   = 1'b0;
          state_nx = MOVE;
        end
      end
      MOVE: begin
        if (timer == MOVE_LAST) begin
          timer_nx = '0;
          floor_nx = step_floor(floor_o, dir_up_o);
          if (pending_o[floor_nx])
            state_nx = DOOR;
          else if (!any_ahead(pending_o, floor_nx, dir_up_o))
            state_nx = IDLE;
        end else begin
          timer_nx = timer + TMR_W'(1);
        end
      end
      DOOR: begin
        // A fresh press for this floor keeps the door open for a full dwell.
        if (req[floor_o])
          timer_nx = '0;
        else if (timer == DOOR_LAST) begin
          timer_nx = '0;
          if (any_ahead(pending_o, floor_o, dir_up_o))
            state_nx = MOVE;
          else if (any_ahead(pending_o, floor_o, !dir_up_o)) begin
            dir_nx   = !dir_up_o;
            state_nx = MOVE;
          end else
            state_nx = IDLE;
        end else begin
          timer_nx = timer + TMR_W'(1);
        end
      end
`ifdef LIFT_EMERG_EN
      EMERG: begin
        timer_nx = '0;
        if (!emerg_i)
          state_nx = IDLE;
      end
`endif
      default: begin
        timer_nx = '0;
        state_nx = IDLE;
      end
    endcase

`ifdef LIFT_EMERG_EN
    // Emergency recall: finish any step in progress, then head for floor 0.
    if (emerg_i) begin
      case (state)
        MOVE: begin
          if (timer == MOVE_LAST) begin
            dir_nx   = 1'b0;
            state_nx = (floor_nx == '0) ? EMERG : MOVE;
          end else
            state_nx = MOVE;
        end
        IDLE, DOOR: begin
          timer_nx = '0;
          dir_nx   = 1'b0;
          state_nx = (floor_o == '0) ? EMERG : MOVE;
        end
        default: state_nx = EMERG;
      endcase
    end
`endif

    clr = '0;
    if ((state == DOOR) || (state_nx == DOOR))
      clr = {{(NUM_FLOORS-1){1'b0}}, 1'b1} << floor_nx;
    pending_nx = (pending_o | req) & ~clr;
`ifdef LIFT_EMERG_EN
    if (emerg_i)
      pending_nx = '0;
    door_nx = (state_nx == DOOR) || (state_nx == EMERG);
`else
    door_nx = (state_nx == DOOR);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      floor_o     <= '0;
      dir_up_o    <= 1'b1;
      timer       <= '0;
      pending_o   <= '0;
      door_open_o <= 1'b0;
      moving_o    <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      state       <= state_nx;
      floor_o     <= floor_nx;
      dir_up_o    <= dir_nx;
      timer       <= timer_nx;
      pending_o   <= pending_nx;
      door_open_o <= door_nx;
      moving_o    <= (state_nx == MOVE);
      busy_o      <= (state_nx != IDLE);
    end
  end

endmodule

// File: tb/tb_lift_ctrl.sv
// Directed bench for lift_ctrl; the emergency sequence runs only when LIFT_EMERG_EN is defined.
module tb_lift_ctrl;

  logic       clk;
  logic       rst;
  logic [7:0] call_req;
  logic [7:0] car_req;
`ifdef LIFT_EMERG_EN
  logic       emerg_i;
`endif
  logic [2:0] floor_o;
  logic       door_open_o;
  logic       moving_o;
  logic       dir_up_o;
  logic       busy_o;
  logic [7:0] pending_o;

  int vectors;
  int miscompares;

  lift_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .call_req    (call_req),
    .car_req     (car_req),
`ifdef LIFT_EMERG_EN
    .emerg_i     (emerg_i),
`endif
    .floor_o     (floor_o),
    .door_open_o (door_open_o),
    .moving_o    (moving_o),
    .dir_up_o    (dir_up_o),
    .busy_o      (busy_o),
    .pending_o   (pending_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst      = 1'b1;
    call_req = '0;
    car_req  = '0;
`ifdef LIFT_EMERG_EN
    emerg_i  = 1'b0;
`endif
    step(2);
    rst = 1'b0;
    chk("rst_floor",   32'(floor_o), 0);
    chk("rst_busy",    32'(busy_o), 0);
    chk("rst_door",    32'(door_open_o), 0);
    chk("rst_moving",  32'(moving_o), 0);
    chk("rst_dir",     32'(dir_up_o), 1);
    chk("rst_pending", 32'(pending_o), 0);

    // floor 0 -> 5
    car_req = 8'h20;
    step(1);
    car_req = '0;
    chk("t2_pend_latched", 32'(pending_o), 32'h20);
    chk("t2_busy_lat1",    32'(busy_o), 0);
    step(1);
    chk("t2_busy",   32'(busy_o), 1);
    chk("t2_moving", 32'(moving_o), 1);
    step(19);
    chk("t2_floor4",  32'(floor_o), 4);
    chk("t2_mov19",   32'(moving_o), 1);
    step(1);
    chk("t2_floor5",  32'(floor_o), 5);
    chk("t2_door",    32'(door_open_o), 1);
    chk("t2_mov_off", 32'(moving_o), 0);
    chk("t2_pclr",    32'(pending_o), 0);
    step(2);
    chk("t2_door3", 32'(door_open_o), 1);
    step(1);
    chk("t2_door_closed", 32'(door_open_o), 0);
    chk("t2_idle",        32'(busy_o), 0);

    // idle at 5, calls at 7 and 1: up first, then reverse
    call_req = 8'h82;
    step(1);
    call_req = '0;
    chk("t4_pend", 32'(pending_o), 32'h82);
    step(1);
    chk("t4_dir_up", 32'(dir_up_o), 1);
    chk("t4_moving", 32'(moving_o), 1);
    step(8);
    chk("t4_floor7", 32'(floor_o), 7);
    chk("t4_door7",  32'(door_open_o), 1);
    chk("t4_pend7",  32'(pending_o), 32'h02);
    step(3);
    chk("t4_dir_down",  32'(dir_up_o), 0);
    chk("t4_moving_dn", 32'(moving_o), 1);
    chk("t4_door_shut", 32'(door_open_o), 0);
    step(24);
    chk("t4_floor1", 32'(floor_o), 1);
    chk("t4_door1",  32'(door_open_o), 1);
    chk("t4_pend0",  32'(pending_o), 0);
    step(3);
    chk("t4_idle", 32'(busy_o), 0);
    chk("t4_dir_kept", 32'(dir_up_o), 0);

    // reset in the middle of a move at floor 3; requests on the reset edge are dropped
    car_req = 8'h40;
    step(1);
    car_req = '0;
    step(9);
    chk("t1_floor3",  32'(floor_o), 3);
    chk("t1_moving3", 32'(moving_o), 1);
    step(2);
    rst     = 1'b1;
    car_req = 8'h10;
    step(1);
    rst     = 1'b0;
    car_req = '0;
    chk("t1_floor",   32'(floor_o), 0);
    chk("t1_busy",    32'(busy_o), 0);
    chk("t1_pending", 32'(pending_o), 0);
    chk("t1_door",    32'(door_open_o), 0);
    chk("t1_moving",  32'(moving_o), 0);
    chk("t1_dir",     32'(dir_up_o), 1);
    step(1);
    chk("t1_req_ignored", 32'(pending_o), 0);

    // floor 0 -> 6 with a hall call at 4 picked up on the way
    car_req = 8'h40;
    step(1);
    car_req = '0;
    step(9);
    chk("t3_floor2", 32'(floor_o), 2);
    call_req = 8'h10;
    step(1);
    call_req = '0;
    chk("t3_pend", 32'(pending_o), 32'h50);
    step(7);
    chk("t3_floor4", 32'(floor_o), 4);
    chk("t3_door4",  32'(door_open_o), 1);
    chk("t3_pend4",  32'(pending_o), 32'h40);
    step(2);
    chk("t3_dwell", 32'(door_open_o), 1);
    step(1);
    chk("t3_resume", 32'(moving_o), 1);
    chk("t3_shut",   32'(door_open_o), 0);
    step(8);
    chk("t3_floor6", 32'(floor_o), 6);
    chk("t3_door6",  32'(door_open_o), 1);
    chk("t3_pend6",  32'(pending_o), 0);
    step(3);
    chk("t3_idle", 32'(busy_o), 0);

    // floor 6 -> 2, re-press 2 on the second dwell cycle
    car_req = 8'h04;
    step(1);
    car_req = '0;
    step(1);
    chk("t5_dir_down", 32'(dir_up_o), 0);
    step(16);
    chk("t5_floor2", 32'(floor_o), 2);
    chk("t5_door",   32'(door_open_o), 1);
    step(1);
    car_req = 8'h04;
    step(1);
    car_req = '0;
    chk("t5_clear_wins", 32'(pending_o), 0);
    chk("t5_door_c2",    32'(door_open_o), 1);
    step(2);
    chk("t5_door_held", 32'(door_open_o), 1);
    step(1);
    chk("t5_door_closed", 32'(door_open_o), 0);
    chk("t5_idle",        32'(busy_o), 0);

`ifdef LIFT_EMERG_EN
    // floor 2 heading for 6, emergency raised between 3 and 4
    car_req = 8'h40;
    step(1);
    car_req = '0;
    step(5);
    chk("em_floor3", 32'(floor_o), 3);
    step(1);
    emerg_i = 1'b1;
    step(1);
    chk("em_pclr",   32'(pending_o), 0);
    chk("em_floor3b", 32'(floor_o), 3);
    chk("em_moving", 32'(moving_o), 1);
    step(2);
    chk("em_floor4", 32'(floor_o), 4);
    chk("em_dir",    32'(dir_up_o), 0);
    step(16);
    chk("em_floor0", 32'(floor_o), 0);
    chk("em_door",   32'(door_open_o), 1);
    chk("em_busy",   32'(busy_o), 1);
    chk("em_stop",   32'(moving_o), 0);
    emerg_i = 1'b0;
    step(1);
    chk("em_idle",      32'(busy_o), 0);
    chk("em_door_shut", 32'(door_open_o), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
